// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: shadow EX/MEM/WB state, forwarding selects, load-use stall, mispredict flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module ex_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_useRs,
  input  logic                id_useRt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regWrite,
  input  logic                id_memRead,
  input  logic                id_branch,
  input  logic                id_predTaken,
  input  logic                taken,
  output logic [1:0]          forwardA,
  output logic [1:0]          forwardB,
  output logic                stall,
  output logic                flush,
  output logic                mispredict,
  output logic                redirectTaken,
  output logic [CNT_W-1:0]    stallCount,
  output logic [CNT_W-1:0]    flushCount
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                branch;
    logic                pred_taken;
  } stage_t;

  stage_t ex_q, mem_q, wb_q, ex_d;

  logic       ex_prod, mem_prod;
  logic       load_hit, advance;
  logic [1:0] fwd_a_d, fwd_b_d;

  assign ex_prod  = ex_q.valid && ex_q.reg_write && (ex_q.rd != '0);
  assign mem_prod = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);

  assign load_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                    ((id_useRs && (id_rs == ex_q.rd)) ||
                     (id_useRt && (id_rt == ex_q.rd)));

  assign mispredict    = ex_q.valid && ex_q.branch && (taken != ex_q.pred_taken);
  assign flush         = mispredict;
  assign stall         = load_hit && !mispredict;
  assign redirectTaken = taken;
  assign advance       = id_valid && !stall && !flush;

  // EX outranks MEM: the newest producer of a register wins.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (advance && id_useRs) begin
      if (ex_prod && (ex_q.rd == id_rs))
        fwd_a_d = 2'b10;
      else if (mem_prod && (mem_q.rd == id_rs))
        fwd_a_d = 2'b01;
    end
    if (advance && id_useRt) begin
      if (ex_prod && (ex_q.rd == id_rt))
        fwd_b_d = 2'b10;
      else if (mem_prod && (mem_q.rd == id_rt))
        fwd_b_d = 2'b01;
    end
  end

  always_comb begin
    ex_d = '0;
    if (advance) begin
      ex_d.valid      = 1'b1;
      ex_d.rd         = id_rd;
      ex_d.reg_write  = id_regWrite;
      ex_d.mem_read   = id_memRead;
      ex_d.branch     = id_branch;
      ex_d.pred_taken = id_predTaken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      forwardA <= 2'b00;
      forwardB <= 2'b00;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      forwardA <= fwd_a_d;
      forwardB <= fwd_b_d;
    end
  end

  // WB and the tail of MEM are kept for visibility only; nothing reads them.
  logic unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.mem_read, mem_q.branch, mem_q.pred_taken};

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && (stallCount != '1))
        stallCount <= stallCount + 1'b1;
      if (flush && (flushCount != '1))
        flushCount <= flushCount + 1'b1;
    end
  end
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: forwarding, load-use, mispredict, r0, reset.
// Expected selects are queued when an instruction is driven in ID and popped when it sits in EX.
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_useRs, id_useRt;
  logic        id_regWrite, id_memRead, id_branch, id_predTaken;
  logic        taken;
  logic [1:0]  forwardA, forwardB;
  logic        stall, flush, mispredict, redirectTaken;
  logic [31:0] stallCount, flushCount;

  int errors = 0;
  int checks = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  logic [3:0] fwd_q[$];

  always #5 clk = ~clk;

  ex_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_useRs      (id_useRs),
    .id_useRt      (id_useRt),
    .id_rd         (id_rd),
    .id_regWrite   (id_regWrite),
    .id_memRead    (id_memRead),
    .id_branch     (id_branch),
    .id_predTaken  (id_predTaken),
    .taken         (taken),
    .forwardA      (forwardA),
    .forwardB      (forwardB),
    .stall         (stall),
    .flush         (flush),
    .mispredict    (mispredict),
    .redirectTaken (redirectTaken),
    .stallCount    (stallCount),
    .flushCount    (flushCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
`ifdef HAZARD_STATS_EN
    chk({tag, "/stallCount"}, stallCount, exp_sc);
    chk({tag, "/flushCount"}, flushCount, exp_fc);
`else
    chk({tag, "/stallCount"}, stallCount, 0);
    chk({tag, "/flushCount"}, flushCount, 0);
`endif
  endtask

  task automatic step(
    input string tag,
    input logic v, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic [4:0] rd,
    input logic rw, input logic mr, input logic br, input logic pt,
    input logic tk,
    input logic e_stall, input logic e_flush,
    input logic [1:0] e_fa, input logic [1:0] e_fb
  );
    logic [3:0] sel;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt;
    id_useRs = urs; id_useRt = urt; id_rd = rd;
    id_regWrite = rw; id_memRead = mr;
    id_branch = br; id_predTaken = pt; taken = tk;
    #1;
    chk({tag, "/stall"}, stall, e_stall);
    chk({tag, "/flush"}, flush, e_flush);
    chk({tag, "/mispredict"}, mispredict, e_flush);
    chk({tag, "/redirectTaken"}, redirectTaken, tk);
    if (fwd_q.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 1, 0);
    end else begin
      sel = fwd_q.pop_front();
      chk({tag, "/forwardA"}, forwardA, sel[3:2]);
      chk({tag, "/forwardB"}, forwardB, sel[1:0]);
    end
    chk_counters(tag);
    if (v && !e_stall && !e_flush)
      fwd_q.push_back({e_fa, e_fb});
    else
      fwd_q.push_back(4'b0000);
    if (e_stall) exp_sc++;
    if (e_flush) exp_fc++;
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "/stall"}, stall, 0);
    chk({tag, "/flush"}, flush, 0);
    chk({tag, "/mispredict"}, mispredict, 0);
    chk({tag, "/forwardA"}, forwardA, 0);
    chk({tag, "/forwardB"}, forwardB, 0);
    exp_sc = 0;
    exp_fc = 0;
    chk_counters(tag);
    fwd_q.delete();
    fwd_q.push_back(4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_useRs = 0; id_useRt = 0; id_regWrite = 0; id_memRead = 0;
    id_branch = 0; id_predTaken = 0; taken = 0;
    @(negedge clk);
    reset_check("reset");
    reset = 1'b0;

    //   tag          v  rs  rt  urs urt rd  rw mr br pt tk  st fl  fa     fb
    step("add_r3",    1, 1,  2,  1,  1,  3,  1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("sub_r4",    1, 3,  5,  1,  1,  4,  1, 0, 0, 0, 0,  0, 0, 2'b10, 2'b00);
    step("or_r6",     1, 7,  3,  1,  1,  6,  1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b01);
    step("add_r3a",   1, 1,  2,  1,  1,  3,  1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("add_r3b",   1, 8,  9,  1,  1,  3,  1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("newest",    1, 3,  0,  1,  1,  10, 1, 0, 0, 0, 0,  0, 0, 2'b10, 2'b00);
    step("lw_r2",     1, 1,  0,  1,  0,  2,  1, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("lu_stall",  1, 2,  2,  1,  1,  8,  1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00);
    step("lu_go",     1, 2,  2,  1,  1,  8,  1, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01);
    step("nop1",      0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("beq_nt",    1, 11, 12, 1,  0,  0,  0, 0, 1, 0, 0,  0, 0, 2'b00, 2'b00);
    step("mispred",   1, 1,  0,  1,  0,  13, 1, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("post_flsh", 1, 1,  0,  1,  0,  14, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("beq_t",     1, 1,  0,  1,  0,  0,  0, 0, 1, 1, 0,  0, 0, 2'b00, 2'b00);
    step("pred_ok",   0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b00);
    step("ld_br",     1, 1,  0,  1,  0,  2,  1, 1, 1, 0, 0,  0, 0, 2'b00, 2'b00);
    step("prio",      1, 2,  2,  1,  1,  8,  1, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("ld_r0",     1, 1,  0,  1,  0,  0,  1, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("use_r0",    1, 0,  0,  1,  1,  9,  1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("nop2",      0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("lw_r2b",    1, 1,  0,  1,  0,  2,  1, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("lu_pend",   1, 2,  4,  1,  1,  5,  1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00);

    reset = 1'b1;
    reset_check("mid_reset");
    reset = 1'b0;
    step("after_rst", 0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);
    step("tail",      0, 0,  0,  0,  0,  0,  0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
